// File: rtl/regfile_ctrl_pkg.sv
// Shared types and default widths for the register-file sequencer slice.
package regfile_ctrl_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [N_DEF-1:0] addr;
    logic [W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_addr_counter.sv
// N-bit wrapping address counter with sync clear, enable and terminal-count flag.
module rf_addr_counter
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] cnt_o,
  output logic         tc_o
);

  logic [N-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + N'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '1);

endmodule

// File: rtl/regfile_ctrl.sv
// Bulk-fill sequencer, write-port arbiter and read-address mux for register_file.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_fill,
  input  logic         man_we,
  input  logic [N-1:0] man_addr,
  input  logic [W-1:0] man_data,
  input  logic [N-1:0] man_rs1,
  input  logic [N-1:0] man_rs2,
  input  logic [W-1:0] rand_in,
  input  logic         scan_en,
  input  logic         scan_tick,
  output logic         rf_we,
  output logic [N-1:0] rf_addr_rd,
  output logic [W-1:0] rf_data_in,
  output logic [N-1:0] rf_addr_rs1,
  output logic [N-1:0] rf_addr_rs2,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  typedef struct packed {
    logic [N-1:0] addr;
    logic [W-1:0] data;
  } req_t;

  state_t       state_q;
  req_t         wr_q, pend_q, man_req, fill_req;
  logic         rf_we_q, busy_q, done_q, ovf_q, pend_vld_q;
  logic         fill_en, fill_tc, scan_tc;
  logic [N-1:0] fill_cnt, scan_cnt;

  assign man_req  = '{addr: man_addr, data: man_data};
  assign fill_req = '{addr: fill_cnt, data: rand_in};

  // Address 0 is issued on the start edge itself, so the counter runs one ahead
  // and wraps back to 0 on the final fill write.
  assign fill_en = (state_q == FILL) || ((state_q == IDLE) && start_fill);

  rf_addr_counter #(.N(N)) u_fill_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (!fill_en),
    .en_i  (fill_en),
    .cnt_o (fill_cnt),
    .tc_o  (fill_tc)
  );

  rf_addr_counter #(.N(N)) u_scan_cnt (
    .clk_i (clk),
    .rst_ni(rst_n),
    .clr_i (1'b0),
    .en_i  (scan_tick && scan_en),
    .cnt_o (scan_cnt),
    .tc_o  (scan_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      rf_we_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
          if ((state_q == IDLE) && start_fill) begin
            state_q <= FILL;
            rf_we_q <= 1'b1;
            busy_q  <= 1'b1;
            wr_q    <= fill_req;
            if (man_we) begin
              if (pend_vld_q) ovf_q <= 1'b1;
              else begin
                pend_vld_q <= 1'b1;
                pend_q     <= man_req;
              end
            end
          end else if (pend_vld_q) begin
            // Pending slot frees on this edge, so a concurrent manual write refills it.
            rf_we_q    <= 1'b1;
            wr_q       <= pend_q;
            pend_vld_q <= man_we;
            if (man_we) pend_q <= man_req;
          end else if (man_we) begin
            rf_we_q <= 1'b1;
            wr_q    <= man_req;
          end
        end
        FILL: begin
          rf_we_q <= 1'b1;
          busy_q  <= 1'b1;
          wr_q    <= fill_req;
          if (fill_tc) state_q <= DONE;
          if (man_we) begin
            if (pend_vld_q) ovf_q <= 1'b1;
            else begin
              pend_vld_q <= 1'b1;
              pend_q     <= man_req;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_addr_rd = wr_q.addr;
  assign rf_data_in = wr_q.data;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;

  assign rf_addr_rs1 = scan_en ? scan_cnt : man_rs1;
  assign rf_addr_rs2 = scan_en ? (scan_tc ? '0 : scan_cnt + N'(1)) : man_rs2;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed self-checking bench for regfile_ctrl.
module tb_regfile_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_fill, man_we, scan_en, scan_tick;
  logic [3:0] man_addr, man_rs1, man_rs2;
  logic [7:0] man_data, rand_in;
  logic       rf_we, busy, done, ovf;
  logic [3:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
  logic [7:0] rf_data_in;

  int unsigned checks = 0;
  int unsigned errors = 0;

  regfile_ctrl #(.N(4), .W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_fill (start_fill),
    .man_we     (man_we),
    .man_addr   (man_addr),
    .man_data   (man_data),
    .man_rs1    (man_rs1),
    .man_rs2    (man_rs2),
    .rand_in    (rand_in),
    .scan_en    (scan_en),
    .scan_tick  (scan_tick),
    .rf_we      (rf_we),
    .rf_addr_rd (rf_addr_rd),
    .rf_data_in (rf_data_in),
    .rf_addr_rs1(rf_addr_rs1),
    .rf_addr_rs2(rf_addr_rs2),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int we, input int addr, input int data);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_addr"}, 32'(rf_addr_rd), 32'(addr));
    chk({tag, "_data"}, 32'(rf_data_in), 32'(data));
  endtask

  // Runs a full fill with rand_in = i+1 at fill step i; optional manual writes at given steps.
  task automatic run_fill(input string tag, input int mw_step0, input int mw_addr0, input int mw_data0,
                          input int mw_step1, input int mw_addr1, input int mw_data1);
    rand_in    = 8'h01;
    start_fill = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      start_fill = 1'b0;
      man_we     = 1'b0;
      chk_wr($sformatf("%s_fill%0d", tag, i), 1, i, i + 1);
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'(1));
      chk($sformatf("%s_done%0d", tag, i), 32'(done), 32'(0));
      rand_in = 8'(i + 2);
      if (i == mw_step0) begin
        man_we = 1'b1; man_addr = 4'(mw_addr0); man_data = 8'(mw_data0);
      end
      if (i == mw_step1) begin
        man_we = 1'b1; man_addr = 4'(mw_addr1); man_data = 8'(mw_data1);
      end
    end
    tick();
    man_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_fill = 1'b0; man_we = 1'b0; scan_en = 1'b0; scan_tick = 1'b0;
    man_addr = '0; man_data = '0; man_rs1 = '0; man_rs2 = '0; rand_in = '0;
    #3;
    chk_wr("rst", 0, 0, 0);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Manual write in IDLE, 1-cycle latency
    man_we = 1'b1; man_addr = 4'd3; man_data = 8'hA5;
    tick();
    man_we = 1'b0;
    chk_wr("man", 1, 3, 8'hA5);
    tick();
    chk_wr("man_hold", 0, 3, 8'hA5);

    // Plain fill
    run_fill("f1", -1, 0, 0, -1, 0, 0);
    chk("f1_done", 32'(done), 32'(1));
    chk("f1_busy_end", 32'(busy), 32'(0));
    chk("f1_we_end", 32'(rf_we), 32'(0));
    tick();
    chk("f1_done_pulse", 32'(done), 32'(0));

    // One manual write during fill issues in DONE
    run_fill("f2", 5, 7, 8'h3C, -1, 0, 0);
    chk("f2_done", 32'(done), 32'(1));
    chk_wr("f2_pend", 1, 7, 8'h3C);
    chk("f2_ovf", 32'(ovf), 32'(0));
    tick();
    chk("f2_we_after", 32'(rf_we), 32'(0));

    // Two manual writes: second dropped, ovf sticky
    run_fill("f3", 2, 2, 8'h11, 9, 9, 8'h22);
    chk_wr("f3_pend", 1, 2, 8'h11);
    chk("f3_ovf", 32'(ovf), 32'(1));
    tick();
    chk("f3_we_after", 32'(rf_we), 32'(0));
    tick(); tick();
    chk("f3_ovf_sticky", 32'(ovf), 32'(1));

    // Async reset mid-fill
    rand_in = 8'h50;
    start_fill = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      start_fill = 1'b0;
      chk($sformatf("f4_addr%0d", i), 32'(rf_addr_rd), 32'(i));
    end
    #2 rst_n = 1'b0;
    #1;
    chk("f4_rst_we", 32'(rf_we), 32'(0));
    chk("f4_rst_busy", 32'(busy), 32'(0));
    chk("f4_rst_done", 32'(done), 32'(0));
    chk("f4_rst_ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("f4_no_resume_we", 32'(rf_we), 32'(0));
    chk("f4_no_resume_busy", 32'(busy), 32'(0));
    man_we = 1'b1; man_addr = 4'd5; man_data = 8'h66;
    tick();
    man_we = 1'b0;
    chk_wr("f4_man", 1, 5, 8'h66);
    chk("f4_man_busy", 32'(busy), 32'(0));

    // Scan counter and read mux
    scan_en = 1'b1;
    #1;
    chk("scan0_rs1", 32'(rf_addr_rs1), 32'(0));
    chk("scan0_rs2", 32'(rf_addr_rs2), 32'(1));
    for (int k = 1; k <= 17; k++) begin
      scan_tick = 1'b1;
      tick();
      scan_tick = 1'b0;
      chk($sformatf("scan%0d_rs1", k), 32'(rf_addr_rs1), 32'(k % 16));
      chk($sformatf("scan%0d_rs2", k), 32'(rf_addr_rs2), 32'((k + 1) % 16));
    end
    scan_en = 1'b0; man_rs1 = 4'd4; man_rs2 = 4'd9;
    #1;
    chk("sw_rs1", 32'(rf_addr_rs1), 32'(4));
    chk("sw_rs2", 32'(rf_addr_rs2), 32'(9));
    scan_tick = 1'b1;
    tick();
    scan_tick = 1'b0;
    scan_en = 1'b1;
    #1;
    chk("scan_hold_rs1", 32'(rf_addr_rs1), 32'(1));
    chk("scan_hold_rs2", 32'(rf_addr_rs2), 32'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
